// File: rtl/toggle_cover_pkg.sv
// Shared definitions for the toggle-coverage feeder: cover point layout and
// the derived width of the covered-point counter.
package toggle_cover_pkg;

  localparam int unsigned RISE_OFS       = 0;
  localparam int unsigned FALL_OFS       = 1;
  localparam int unsigned POINTS_PER_BIT = 2;

  // Enough bits to hold every count from 0 up to and including 2*width.
  function automatic int unsigned cover_cnt_w(input int unsigned width);
    return $clog2(POINTS_PER_BIT * width + 1);
  endfunction

endpackage

// File: rtl/toggle_cover_bit.sv
// Per-signal edge detector: keeps the previous sample and the sticky hit state
// of this bit's rise and fall cover points.
module toggle_cover_bit
  import toggle_cover_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       armed,
  input  logic       sig,
  output logic [1:0] hit,
  output logic [1:0] new_hit
);

  logic       prev;
  logic [1:0] seen;

  always_comb begin
    hit           = '0;
    hit[RISE_OFS] = armed & ~prev & sig;
    hit[FALL_OFS] = armed & prev & ~sig;
    new_hit       = hit & ~seen;
  end

  // The sample is taken even during clear, so the following cycle compares
  // against the value seen in the clear cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev <= 1'b0;
      seen <= '0;
    end else begin
      prev <= sig;
      if (clear) seen <= '0;
      else       seen <= seen | hit;
    end
  end

endmodule

// File: rtl/toggle_cover_detect.sv
// Toggle-coverage feeder: registered rise/fall cover pulses per monitored bit,
// with optional report-once suppression and a running covered-point count.
module toggle_cover_detect
  import toggle_cover_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter bit          REPORT_ONCE = 1'b1,
  parameter int unsigned CNT_W       = cover_cnt_w(WIDTH)
)
(
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   sig,
  input  logic               clear,
  output logic [2*WIDTH-1:0] valid,
  output logic [CNT_W-1:0]   covered_count,
  output logic               all_covered
);

  localparam int unsigned NPTS = POINTS_PER_BIT * WIDTH;

  logic             armed;
  logic [NPTS-1:0]  hit;
  logic [NPTS-1:0]  new_hit;
  logic [CNT_W-1:0] pop;
  logic [CNT_W-1:0] count_nxt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    toggle_cover_bit u_bit (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear),
      .armed   (armed),
      .sig     (sig[g]),
      .hit     (hit[POINTS_PER_BIT*g +: POINTS_PER_BIT]),
      .new_hit (new_hit[POINTS_PER_BIT*g +: POINTS_PER_BIT])
    );
  end

  always_comb begin
    pop = '0;
    for (int unsigned p = 0; p < NPTS; p++) begin
      pop = pop + CNT_W'(new_hit[p]);
    end
    count_nxt = covered_count + pop;
  end

  // Clear leaves armed untouched so a clear right after reset still skips
  // reporting until a normal cycle has taken a sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed         <= 1'b0;
      valid         <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else if (clear) begin
      valid         <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else begin
      armed         <= 1'b1;
      valid         <= REPORT_ONCE ? new_hit : hit;
      covered_count <= count_nxt;
      all_covered   <= (count_nxt == CNT_W'(NPTS));
    end
  end

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Bench for toggle_cover_detect: directed vector table plus randomized run
// against a set-based reference model, covering both reporting modes.
module tb_toggle_cover_detect;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [1:0] sig   = 2'b00;

  logic [3:0] valid1, valid0;
  logic [2:0] cnt1, cnt0;
  logic       all1, all0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  toggle_cover_detect #(.WIDTH(2), .REPORT_ONCE(1'b1)) dut_once (
    .clock         (clock),
    .reset         (reset),
    .sig           (sig),
    .clear         (clear),
    .valid         (valid1),
    .covered_count (cnt1),
    .all_covered   (all1)
  );

  toggle_cover_detect #(.WIDTH(2), .REPORT_ONCE(1'b0)) dut_every (
    .clock         (clock),
    .reset         (reset),
    .sig           (sig),
    .clear         (clear),
    .valid         (valid0),
    .covered_count (cnt0),
    .all_covered   (all0)
  );

  // Reference model: the set of cover points hit since reset/clear.
  bit [1:0] prev_m;
  bit       armed_m;
  bit       seen_m [4];
  bit [3:0] ev1, ev0;
  int       ecnt;
  bit       eall;

  task automatic model_step(input bit r, input bit c, input bit [1:0] s);
    bit h;
    int i;
    ev1 = '0;
    ev0 = '0;
    if (r) begin
      prev_m  = 2'b00;
      armed_m = 1'b0;
      foreach (seen_m[p]) seen_m[p] = 1'b0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        i = p / 2;
        if (p % 2 == 0) h = armed_m && !prev_m[i] && s[i];
        else            h = armed_m && prev_m[i] && !s[i];
        if (c) begin
          seen_m[p] = 1'b0;
        end else begin
          ev0[p] = h;
          ev1[p] = h && !seen_m[p];
          if (h) seen_m[p] = 1'b1;
        end
      end
      prev_m = s;
      if (!c) armed_m = 1'b1;
    end
    ecnt = 0;
    foreach (seen_m[p]) if (seen_m[p]) ecnt++;
    eall = (ecnt == 4);
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, step, act, req);
    end
  endtask

  task automatic apply(input bit r, input bit c, input bit [1:0] s);
    reset = r;
    clear = c;
    sig   = s;
    @(posedge clock);
    #1;
    model_step(r, c, s);
  endtask

  typedef struct {
    bit       r;
    bit       c;
    bit [1:0] s;
    bit [3:0] v1;
    bit [3:0] v0;
    int       cnt;
    bit       all;
  } vec_t;

  vec_t tbl [24];

  initial begin
    // reset release with 11 held, then bit 1 falls
    tbl[0]  = '{1, 0, 2'b11, 4'b0000, 4'b0000, 0, 0};
    tbl[1]  = '{0, 0, 2'b11, 4'b0000, 4'b0000, 0, 0};
    tbl[2]  = '{0, 0, 2'b01, 4'b1000, 4'b1000, 1, 0};
    // bit 0 toggles 0-1-0-1-0
    tbl[3]  = '{1, 0, 2'b00, 4'b0000, 4'b0000, 0, 0};
    tbl[4]  = '{0, 0, 2'b00, 4'b0000, 4'b0000, 0, 0};
    tbl[5]  = '{0, 0, 2'b01, 4'b0001, 4'b0001, 1, 0};
    tbl[6]  = '{0, 0, 2'b00, 4'b0010, 4'b0010, 2, 0};
    tbl[7]  = '{0, 0, 2'b01, 4'b0000, 4'b0001, 2, 0};
    tbl[8]  = '{0, 0, 2'b00, 4'b0000, 4'b0010, 2, 0};
    // both bits rise then fall together
    tbl[9]  = '{1, 0, 2'b00, 4'b0000, 4'b0000, 0, 0};
    tbl[10] = '{0, 0, 2'b00, 4'b0000, 4'b0000, 0, 0};
    tbl[11] = '{0, 0, 2'b11, 4'b0101, 4'b0101, 2, 0};
    tbl[12] = '{0, 0, 2'b00, 4'b1010, 4'b1010, 4, 1};
    // clear on a bit-0 rise, then bit 0 falls
    tbl[13] = '{0, 1, 2'b01, 4'b0000, 4'b0000, 0, 0};
    tbl[14] = '{0, 0, 2'b00, 4'b0010, 4'b0010, 1, 0};
    // bit 1 toggles every cycle
    tbl[15] = '{0, 0, 2'b10, 4'b0100, 4'b0100, 2, 0};
    tbl[16] = '{0, 0, 2'b00, 4'b1000, 4'b1000, 3, 0};
    tbl[17] = '{0, 0, 2'b10, 4'b0000, 4'b0100, 3, 0};
    tbl[18] = '{0, 0, 2'b00, 4'b0000, 4'b1000, 3, 0};
    tbl[19] = '{0, 0, 2'b10, 4'b0000, 4'b0100, 3, 0};
    tbl[20] = '{0, 0, 2'b00, 4'b0000, 4'b1000, 3, 0};
    // reset mid-run at count 3, toggle on first post-reset cycle ignored
    tbl[21] = '{1, 0, 2'b10, 4'b0000, 4'b0000, 0, 0};
    tbl[22] = '{0, 0, 2'b00, 4'b0000, 4'b0000, 0, 0};
    tbl[23] = '{0, 0, 2'b10, 4'b0100, 4'b0100, 1, 0};

    for (int k = 0; k < 24; k++) begin
      apply(tbl[k].r, tbl[k].c, tbl[k].s);
      chk("tbl_valid_once",  k, 32'(valid1), 32'(tbl[k].v1));
      chk("tbl_valid_every", k, 32'(valid0), 32'(tbl[k].v0));
      chk("tbl_count_once",  k, 32'(cnt1),   32'(tbl[k].cnt));
      chk("tbl_count_every", k, 32'(cnt0),   32'(tbl[k].cnt));
      chk("tbl_all_once",    k, 32'(all1),   32'(tbl[k].all));
      chk("tbl_all_every",   k, 32'(all0),   32'(tbl[k].all));
    end

    // clear in the very first cycle after reset keeps reporting disarmed
    apply(1'b1, 1'b0, 2'b00);
    apply(1'b0, 1'b1, 2'b01);
    apply(1'b0, 1'b0, 2'b00);
    chk("clear_unarmed_valid", 0, 32'(valid0), 32'(4'b0000));
    apply(1'b0, 1'b0, 2'b01);
    chk("clear_unarmed_rearm", 0, 32'(valid1), 32'(4'b0001));

    for (int k = 0; k < 600; k++) begin
      bit r, c;
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 9) == 0);
      apply(r, c, 2'($urandom));
      chk("rnd_valid_once",  k, 32'(valid1), 32'(ev1));
      chk("rnd_valid_every", k, 32'(valid0), 32'(ev0));
      chk("rnd_count_once",  k, 32'(cnt1),   32'(ecnt));
      chk("rnd_count_every", k, 32'(cnt0),   32'(ecnt));
      chk("rnd_all_once",    k, 32'(all1),   32'(eall));
      chk("rnd_all_every",   k, 32'(all0),   32'(eall));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
